vec_work_dispatcher: RTL and testbench
======================================

// Module: vec_work_dispatcher
// PURPOSE
//   Parametrised work dispatcher for the vector unit.
//   - Buffers incoming work selects in a FIFO.
//   - Each cycle, hands at most one buffered item to one idle consumer, chosen round-robin.
//   - Sits between the instruction decode / issue path and N_CONS vector consumer lanes.
//   - Replaces the single-consumer, unbuffered combinational select pass-through.
// PARAMETERS
//   WORK_W  6  width of one work/select word
//   DEPTH   4  FIFO entries; power of two, >= 2
//   N_CONS  2  number of consumer lanes, >= 1
// PORTS
//   clk_i           in   1               clock, rising edge
//   rst_i           in   1               reset, asynchronous, active-high
//   work_valid_i    in   1               producer offers work_i this cycle
//   work_i          in   WORK_W          work select word
//   work_ready_o    out  1               FIFO can accept; 1 = not full
//   cons_busy_i     in   N_CONS          bit k = 1: consumer k busy
//   select_o        out  N_CONS*WORK_W   slice k = word issued to consumer k, else 0
//   select_valid_o  out  N_CONS          bit k: one-cycle issue strobe to consumer k
//   fifo_count_o    out  $clog2(DEPTH)+1 number of occupied FIFO entries
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - FIFO flushed; fifo_count_o = 0, work_ready_o = 1.
//     - select_o = 0, select_valid_o = 0, rr pointer = 0, hold-off mask = 0.
//   Reset mid-operation: buffered items are discarded. Nothing is replayed.
//   Push: occurs when work_valid_i && work_ready_o.
//     - work_ready_o = !full; it is a combinational function of count only.
//     - When full, push is refused even if a pop happens in the same cycle.
//   Eligibility:
//     - Consumer k is eligible when cons_busy_i[k] == 0 and select_valid_o[k] == 0.
//     - The second term is the hold-off: a consumer issued at cycle t is ineligible
//       at t+1, which covers its one-cycle busy-assert latency.
//   Pop/issue: occurs when FIFO is non-empty and at least one consumer is eligible.
//     - Grant k = first eligible index scanning rr, rr+1, ..., wrapping mod N_CONS.
//     - Registered: on the next edge, select_valid_o[k] = 1 and slice k of select_o = head word.
//     - All other strobes and slices are 0.
//     - rr <= (k+1) mod N_CONS.
//   No issue this cycle: next cycle, all select_valid_o = 0 and select_o = 0.
//   Latency: an item pushed at edge t (FIFO empty) appears on outputs at edge t+1 at the earliest.
//     - There is no bypass path.
//   Simultaneous push and pop: count unchanged; FIFO order strictly preserved.
//   Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally.
//     - Full/empty are derived from count.
//   Count: fifo_count_o = count (registered). It never exceeds DEPTH and never underflows.
//   All consumers busy: FIFO holds and keeps filling; work_ready_o drops at count == DEPTH.
// STRUCTURE
//   - Package vecunit_pkg:
//     - default localparams VEC_WORK_W = 6, VEC_DISP_DEPTH = 4, VEC_N_CONS = 2;
//     - function rr_pick(eligible, rr) returning the grant index.
//   - Sub-module vec_work_fifo: sync FIFO with push/pop/count/full/empty, parameters WORK_W and DEPTH.
//   - Top level: arbiter, hold-off mask, and output registers.
// TESTING
//   1. Reset, then push 0x2A with consumers idle (N_CONS=2):
//      -> at edge t+1, select_valid_o = 2'b01, select_o[5:0] = 0x2A, upper slice 0; count back to 0.
//   2. Push 0x01, 0x02, 0x03 back-to-back, consumers idle:
//      -> grants alternate 0, 1, 0 on consecutive cycles, words in order; strobes never on the same lane twice in a row.
//   3. cons_busy_i = 2'b11, push 5 items into DEPTH=4:
//      -> work_ready_o = 0 after the 4th push, 5th push refused, count = 4, no strobes.
//      -> Then release busy: 4 items drain in FIFO order.
//   4. Full FIFO, push and pop offered in the same cycle:
//      -> push refused, count 4 -> 3.
//      -> With count = 2, simultaneous push and pop: count stays 2, order intact.
//   5. cons_busy_i = 2'b01 with rr = 0:
//      -> grant goes to lane 1.
//      -> Lane 1 held off the next cycle, so no issue even with the FIFO non-empty.
//   6. Assert rst_i while count = 3 and a strobe is active:
//      -> outputs 0 and count 0 immediately (async); the first item after release dispatches to lane 0.

Source files
------------

// File: rtl/vecunit_pkg.sv
// Shared definitions for the vector-unit work dispatcher.
//   VEC_WORK_W / VEC_DISP_DEPTH / VEC_N_CONS : default dispatcher geometry
//   VEC_MAX_CONS                             : widest consumer vector rr_pick accepts
//   rr_pick(eligible, rr, n_cons)            : round-robin grant index
package vecunit_pkg;

  localparam int VEC_WORK_W     = 6;
  localparam int VEC_DISP_DEPTH = 4;
  localparam int VEC_N_CONS     = 2;
  localparam int VEC_MAX_CONS   = 16;
  localparam int VEC_MAX_CONS_W = 4;

  // First set bit of eligible when scanning rr, rr+1, ... modulo n_cons.
  // Falls back to rr when nothing is eligible; callers gate on |eligible.
  function automatic int unsigned rr_pick(input logic [VEC_MAX_CONS-1:0] eligible,
                                          input int unsigned rr,
                                          input int unsigned n_cons);
    int unsigned idx;
    logic        found;
    rr_pick = rr;
    found   = 1'b0;
    for (int unsigned i = 0; i < VEC_MAX_CONS; i++) begin
      idx = (rr + i) % n_cons;
      if (!found && (i < n_cons) && eligible[idx[VEC_MAX_CONS_W-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/vec_work_fifo.sv
// Synchronous FIFO holding pending work words.
//   clk, rst      : clock, async active-high reset (flushes pointers and count)
//   push, wdata   : write wdata at tail; caller guarantees !full
//   pop, rdata    : rdata is the head word (valid when !empty); pop advances head
//   count         : occupied entries, 0..DEPTH
//   full, empty   : decoded from count
module vec_work_fifo #(
  parameter int WORK_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WORK_W-1:0]          wdata,
  input  logic                       pop,
  output logic [WORK_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_q;

  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem[rd_ptr];

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers are log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vec_work_dispatcher.sv
// Buffers work selects and issues at most one per cycle to an idle consumer lane,
// chosen round-robin.
//   clk_i, rst_i    : clock, async active-high reset
//   work_valid_i    : producer offers work_i; accepted when work_ready_o
//   work_i          : work select word
//   work_ready_o    : FIFO not full (function of count only)
//   cons_busy_i     : per-lane busy
//   select_o        : slice k carries the word issued to lane k, else 0
//   select_valid_o  : per-lane one-cycle issue strobe
//   fifo_count_o    : buffered entries
module vec_work_dispatcher
  import vecunit_pkg::*;
#(
  parameter int WORK_W = VEC_WORK_W,
  parameter int DEPTH  = VEC_DISP_DEPTH,
  parameter int N_CONS = VEC_N_CONS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       work_valid_i,
  input  logic [WORK_W-1:0]          work_i,
  output logic                       work_ready_o,
  input  logic [N_CONS-1:0]          cons_busy_i,
  output logic [N_CONS*WORK_W-1:0]   select_o,
  output logic [N_CONS-1:0]          select_valid_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);

  localparam int RR_W = (N_CONS > 1) ? $clog2(N_CONS) : 1;

  logic                            push, pop, full, empty;
  logic [WORK_W-1:0]               head;
  logic [N_CONS-1:0]               eligible;
  logic [N_CONS-1:0]               vld_q;
  logic [N_CONS-1:0][WORK_W-1:0]   sel_q;
  logic [RR_W-1:0]                 rr_q, grant, rr_next;

  vec_work_fifo #(.WORK_W(WORK_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (work_i),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count_o),
    .full  (full),
    .empty (empty)
  );

  // A lane strobed last cycle has not yet raised busy, so the strobe itself
  // doubles as the hold-off mask.
  assign eligible     = ~cons_busy_i & ~vld_q;
  assign pop          = !empty && (|eligible);
  assign push         = work_valid_i && !full;
  assign work_ready_o = !full;

  assign grant   = RR_W'(rr_pick(VEC_MAX_CONS'(eligible), 32'(rr_q), N_CONS));
  assign rr_next = (grant == RR_W'(N_CONS - 1)) ? '0 : grant + RR_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      sel_q <= '0;
      rr_q  <= '0;
    end else begin
      vld_q <= '0;
      sel_q <= '0;
      if (pop) begin
        vld_q[grant] <= 1'b1;
        sel_q[grant] <= head;
        rr_q         <= rr_next;
      end
    end
  end

  assign select_valid_o = vld_q;
  assign select_o       = sel_q;

endmodule

// File: tb/tb_vec_work_dispatcher.sv
// Self-checking bench for vec_work_dispatcher (WORK_W=6, DEPTH=4, N_CONS=2).
// A queue-based reference model predicts strobes, words, count and ready.
module tb_vec_work_dispatcher;

  localparam int W = 6;
  localparam int D = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           work_valid;
  logic [W-1:0]   work;
  logic           ready;
  logic [N-1:0]   busy;
  logic [N*W-1:0] select;
  logic [N-1:0]   select_valid;
  logic [2:0]     count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0]   q[$];
  int             rr;
  logic [N-1:0]   exp_sv;
  logic [N*W-1:0] exp_sel;
  logic [2:0]     exp_cnt;
  logic           exp_rdy, obs_rdy;

  vec_work_dispatcher #(.WORK_W(W), .DEPTH(D), .N_CONS(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .work_valid_i   (work_valid),
    .work_i         (work),
    .work_ready_o   (ready),
    .cons_busy_i    (busy),
    .select_o       (select),
    .select_valid_o (select_valid),
    .fifo_count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    rr      = 0;
    exp_sv  = '0;
    exp_sel = '0;
    exp_cnt = '0;
  endtask

  // Drive one cycle of stimulus, advance the model, return 1 time unit after the edge.
  task automatic step(input logic v, input logic [W-1:0] w, input logic [N-1:0] b);
    logic [N-1:0]   elig, nsv;
    logic [N*W-1:0] nsel;
    logic           pushing;
    int             k;
    work_valid = v;
    work       = w;
    busy       = b;
    #1;
    exp_rdy = (q.size() < D);
    obs_rdy = ready;
    pushing = v && exp_rdy;
    elig    = ~b & ~exp_sv;
    nsv     = '0;
    nsel    = '0;
    if (q.size() > 0 && elig != '0) begin
      k = rr;
      while (!elig[k]) k = (k + 1) % N;
      nsv[k]          = 1'b1;
      nsel[k*W +: W]  = q.pop_front();
      rr              = (k + 1) % N;
    end
    if (pushing) q.push_back(w);
    @(posedge clk);
    #1;
    exp_sv  = nsv;
    exp_sel = nsel;
    exp_cnt = 3'(q.size());
  endtask

  task automatic apply_reset();
    work_valid = 1'b0;
    work       = '0;
    busy       = '0;
    rst        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    work_valid = 1'b0;
    work       = '0;
    busy       = '0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (select_valid !== '0 || select !== '0 || count !== 3'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_held: sv=%b sel=%h cnt=%0d rdy=%b, want 0/0/0/1", select_valid, select, count, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, '0, '0);
    checks++;
    if (select_valid !== '0 || select !== '0 || count !== 3'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: sv=%b sel=%h cnt=%0d rdy=%b, want 0/0/0/1", select_valid, select, count, ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    step(1'b1, 6'h2A, 2'b00);
    checks++;
    if (select_valid !== 2'b00 || count !== 3'd1) begin
      failures++;
      $display("FAIL single_push: sv=%b cnt=%0d, want 00/1", select_valid, count);
    end
    step(1'b0, '0, 2'b00);
    checks++;
    if (select_valid !== 2'b01 || select !== 12'h02A || count !== 3'd0) begin
      failures++;
      $display("FAIL single_issue: sv=%b sel=%h cnt=%0d, want 01/02a/0", select_valid, select, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] lanes [5];
    lanes = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, W'(i + 1), 2'b00);
      checks++;
      if (select_valid !== lanes[i] || select_valid !== exp_sv || select !== exp_sel || count !== exp_cnt) begin
        failures++;
        $display("FAIL b2b cyc%0d: sv=%b sel=%h cnt=%0d, want sv=%b sel=%h cnt=%0d",
                 i, select_valid, select, count, lanes[i], exp_sel, exp_cnt);
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) step(1'b1, W'($urandom_range(0, 63)), 2'b11);
      else       step(1'b0, '0, 2'b00);
      checks++;
      if (obs_rdy !== exp_rdy || select_valid !== exp_sv || select !== exp_sel || count !== exp_cnt) begin
        failures++;
        $display("FAIL full cyc%0d: rdy=%b sv=%b sel=%h cnt=%0d, want rdy=%b sv=%b sel=%h cnt=%0d",
                 i, obs_rdy, select_valid, select, count, exp_rdy, exp_sv, exp_sel, exp_cnt);
      end
      if (i == 4) begin
        checks++;
        if (count !== 3'd4 || ready !== 1'b0 || select_valid !== 2'b00) begin
          failures++;
          $display("FAIL full_hold: cnt=%0d rdy=%b sv=%b, want 4/0/00", count, ready, select_valid);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [N-1:0] bz [7];
    logic         pv [7];
    bz = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10};
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 7) step(pv[i], W'(8 + i), bz[i]);
      else       step(1'b0, '0, 2'b00);
      checks++;
      if (obs_rdy !== exp_rdy || select_valid !== exp_sv || select !== exp_sel || count !== exp_cnt) begin
        failures++;
        $display("FAIL pushpop cyc%0d: rdy=%b sv=%b sel=%h cnt=%0d, want rdy=%b sv=%b sel=%h cnt=%0d",
                 i, obs_rdy, select_valid, select, count, exp_rdy, exp_sv, exp_sel, exp_cnt);
      end
      if (i == 4) begin
        checks++;
        if (obs_rdy !== 1'b0 || count !== 3'd3) begin
          failures++;
          $display("FAIL full_push_pop: rdy=%b cnt=%0d, want 0/3", obs_rdy, count);
        end
      end
      if (i == 6) begin
        checks++;
        if (count !== 3'd2 || select_valid !== 2'b01) begin
          failures++;
          $display("FAIL count2_push_pop: cnt=%0d sv=%b, want 2/01", count, select_valid);
        end
      end
    end
  endtask

  task automatic test_busy_lane();
    apply_reset();
    step(1'b1, 6'h11, 2'b01);
    step(1'b1, 6'h22, 2'b01);
    checks++;
    if (select_valid !== 2'b10 || select !== 12'h440) begin
      failures++;
      $display("FAIL busy_grant: sv=%b sel=%h, want 10/440", select_valid, select);
    end
    step(1'b0, '0, 2'b01);
    checks++;
    if (select_valid !== 2'b00 || select !== '0 || count !== 3'd1) begin
      failures++;
      $display("FAIL holdoff: sv=%b sel=%h cnt=%0d, want 00/000/1", select_valid, select, count);
    end
    step(1'b0, '0, 2'b01);
    checks++;
    if (select_valid !== 2'b10 || select[2*W-1:W] !== 6'h22 || count !== 3'd0) begin
      failures++;
      $display("FAIL after_holdoff: sv=%b sel=%h cnt=%0d, want 10/880/0", select_valid, select, count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(20 + i), 2'b11);
    step(1'b1, 6'h17, 2'b10);
    checks++;
    if (count !== 3'd3 || select_valid !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset: cnt=%0d sv=%b, want 3/01", count, select_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (select_valid !== '0 || select !== '0 || count !== 3'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: sv=%b sel=%h cnt=%0d rdy=%b, want 0/0/0/1", select_valid, select, count, ready);
    end
    model_reset();
    work_valid = 1'b0;
    busy       = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 6'h3C, 2'b00);
    step(1'b0, '0, 2'b00);
    checks++;
    if (select_valid !== 2'b01 || select !== 12'h03C || count !== 3'd0) begin
      failures++;
      $display("FAIL post_reset: sv=%b sel=%h cnt=%0d, want 01/03c/0", select_valid, select, count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 60, W'($urandom_range(0, 63)), N'($urandom_range(0, 3)));
      checks++;
      if (obs_rdy !== exp_rdy || select_valid !== exp_sv || select !== exp_sel || count !== exp_cnt) begin
        failures++;
        $display("FAIL random cyc%0d: rdy=%b sv=%b sel=%h cnt=%0d, want rdy=%b sv=%b sel=%h cnt=%0d",
                 i, obs_rdy, select_valid, select, count, exp_rdy, exp_sv, exp_sel, exp_cnt);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    work_valid = 1'b0;
    work       = '0;
    busy       = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_busy_lane();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
